// File: rtl/screen_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : screen_console_ctrl
// Description : Text console writer for an 80x30 character screen buffer.
//               It handles printable characters, CR/LF, scrolling and
//               clear-screen. Each 16-bit word holds two characters.
//               Optional feature macro: SCREEN_CTRL_BACKSPACE_EN
// Revision    : 1.0 - initial release
// ============================================================================
module screen_console_ctrl #(
    parameter logic [15:0] BUF_START = 16'd0,
    parameter int          COLS_W    = 40,
    parameter int          ROWS      = 30
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CH_VALID,
    input  logic [7:0]  CH_DATA,
    output logic        CH_READY,
    input  logic        CLR_REQ,
    output logic        BUSY,
    output logic [4:0]  CUR_ROW,
    output logic [6:0]  CUR_COL,
    output logic [15:0] RADDR_SCREEN,
    input  logic [15:0] DATA_OUT_SCREEN,
    output logic [15:0] WADDR_SCREEN,
    output logic [15:0] DATA_IN_SCREEN,
    output logic        MW_SCREEN_ON
);

    localparam int          TOTAL_WORDS   = COLS_W * ROWS;
    localparam int          SCROLL_WORDS  = TOTAL_WORDS - COLS_W;
    localparam logic [6:0]  LAST_COL      = 7'(2 * COLS_W - 1);
    localparam logic [4:0]  LAST_ROW      = 5'(ROWS - 1);
    localparam logic [10:0] SCROLL_LAST   = 11'(SCROLL_WORDS - 1);
    localparam logic [10:0] CLRROW_LAST   = 11'(COLS_W - 1);
    localparam logic [10:0] CLRALL_LAST   = 11'(TOTAL_WORDS - 1);
    localparam logic [15:0] ROW_WORDS     = 16'(COLS_W);
    localparam logic [15:0] LAST_ROW_BASE = BUF_START + 16'(SCROLL_WORDS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PUT    = 3'd1,
        SCROLL = 3'd2,
        CLRROW = 3'd3,
        CLRALL = 3'd4
    } state_t;

    state_t      state;
    logic [10:0] word_cnt;
    logic [4:0]  cur_row;
    logic [6:0]  cur_col;
    logic [7:0]  char_q;
    logic        put_advance;
    logic [15:0] raddr;
    logic [15:0] waddr;
    logic        mw_on;
    logic        busy;

    logic        is_printable;
    logic [15:0] cursor_word;

    assign is_printable = (CH_DATA >= 8'h20) && (CH_DATA <= 8'h7E);
    assign cursor_word  = BUF_START + 16'(cur_row) * ROW_WORDS + 16'(cur_col[6:1]);

`ifdef SCREEN_CTRL_BACKSPACE_EN
    logic [6:0]  bs_col;
    logic [15:0] bs_word;

    assign bs_col  = cur_col - 7'd1;
    assign bs_word = BUF_START + 16'(cur_row) * ROW_WORDS + 16'(bs_col[6:1]);
`endif

    assign CH_READY       = (state == IDLE) && !CLR_REQ;
    assign BUSY           = busy;
    assign CUR_ROW        = cur_row;
    assign CUR_COL        = cur_col;
    assign RADDR_SCREEN   = raddr;
    assign WADDR_SCREEN   = waddr;
    assign MW_SCREEN_ON   = mw_on;

    // Write data depends on the word read back in the same cycle.
    always_comb begin
        DATA_IN_SCREEN = 16'h0000;
        case (state)
            PUT:     DATA_IN_SCREEN = cur_col[0] ? {DATA_OUT_SCREEN[15:8], char_q}
                                                 : {char_q, DATA_OUT_SCREEN[7:0]};
            SCROLL:  DATA_IN_SCREEN = DATA_OUT_SCREEN;
            default: DATA_IN_SCREEN = 16'h0000;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            word_cnt    <= 11'd0;
            cur_row     <= 5'd0;
            cur_col     <= 7'd0;
            char_q      <= 8'h00;
            put_advance <= 1'b1;
            raddr       <= 16'h0000;
            waddr       <= 16'h0000;
            mw_on       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CLR_REQ) begin
                        state    <= CLRALL;
                        word_cnt <= 11'd0;
                        raddr    <= BUF_START;
                        waddr    <= BUF_START;
                        mw_on    <= 1'b1;
                        busy     <= 1'b1;
                    end else if (CH_VALID) begin
                        if (is_printable) begin
                            char_q      <= CH_DATA;
                            put_advance <= 1'b1;
                            state       <= PUT;
                            raddr       <= cursor_word;
                            waddr       <= cursor_word;
                            mw_on       <= 1'b1;
                            busy        <= 1'b1;
                        end else if (CH_DATA == 8'h0A) begin
                            cur_col <= 7'd0;
                            if (cur_row == LAST_ROW) begin
                                state    <= SCROLL;
                                word_cnt <= 11'd0;
                                raddr    <= BUF_START + ROW_WORDS;
                                waddr    <= BUF_START;
                                mw_on    <= 1'b1;
                                busy     <= 1'b1;
                            end else begin
                                cur_row <= cur_row + 5'd1;
                            end
                        end else if (CH_DATA == 8'h0D) begin
                            cur_col <= 7'd0;
`ifdef SCREEN_CTRL_BACKSPACE_EN
                        end else if ((CH_DATA == 8'h08) && (cur_col != 7'd0)) begin
                            // Step back first, then blank the character there in place.
                            cur_col     <= bs_col;
                            char_q      <= 8'h00;
                            put_advance <= 1'b0;
                            state       <= PUT;
                            raddr       <= bs_word;
                            waddr       <= bs_word;
                            mw_on       <= 1'b1;
                            busy        <= 1'b1;
`endif
                        end
                    end
                end

                PUT: begin
                    if (put_advance && (cur_col == LAST_COL)) begin
                        cur_col <= 7'd0;
                        if (cur_row == LAST_ROW) begin
                            state    <= SCROLL;
                            word_cnt <= 11'd0;
                            raddr    <= BUF_START + ROW_WORDS;
                            waddr    <= BUF_START;
                        end else begin
                            cur_row <= cur_row + 5'd1;
                            state   <= IDLE;
                            mw_on   <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end else begin
                        if (put_advance) begin
                            cur_col <= cur_col + 7'd1;
                        end
                        state <= IDLE;
                        mw_on <= 1'b0;
                        busy  <= 1'b0;
                    end
                end

                SCROLL: begin
                    if (word_cnt == SCROLL_LAST) begin
                        state    <= CLRROW;
                        word_cnt <= 11'd0;
                        raddr    <= LAST_ROW_BASE;
                        waddr    <= LAST_ROW_BASE;
                    end else begin
                        word_cnt <= word_cnt + 11'd1;
                        raddr    <= raddr + 16'd1;
                        waddr    <= waddr + 16'd1;
                    end
                end

                CLRROW: begin
                    if (word_cnt == CLRROW_LAST) begin
                        state <= IDLE;
                        mw_on <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        word_cnt <= word_cnt + 11'd1;
                        raddr    <= raddr + 16'd1;
                        waddr    <= waddr + 16'd1;
                    end
                end

                CLRALL: begin
                    if (word_cnt == CLRALL_LAST) begin
                        state   <= IDLE;
                        mw_on   <= 1'b0;
                        busy    <= 1'b0;
                        cur_row <= 5'd0;
                        cur_col <= 7'd0;
                    end else begin
                        word_cnt <= word_cnt + 11'd1;
                        raddr    <= raddr + 16'd1;
                        waddr    <= waddr + 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    mw_on <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_screen_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_screen_console_ctrl
// Description : Scoreboard bench for screen_console_ctrl against a character
//               grid model of the screen and an expected-write queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_console_ctrl;

    localparam int NCOL = 80;
    localparam int NROW = 30;
    localparam int WPR  = 40;
    localparam int NW   = 1200;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CH_VALID;
    logic [7:0]  CH_DATA;
    logic        CH_READY;
    logic        CLR_REQ;
    logic        BUSY;
    logic [4:0]  CUR_ROW;
    logic [6:0]  CUR_COL;
    logic [15:0] RADDR_SCREEN;
    logic [15:0] DATA_OUT_SCREEN;
    logic [15:0] WADDR_SCREEN;
    logic [15:0] DATA_IN_SCREEN;
    logic        MW_SCREEN_ON;

    screen_console_ctrl dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .CH_VALID        (CH_VALID),
        .CH_DATA         (CH_DATA),
        .CH_READY        (CH_READY),
        .CLR_REQ         (CLR_REQ),
        .BUSY            (BUSY),
        .CUR_ROW         (CUR_ROW),
        .CUR_COL         (CUR_COL),
        .RADDR_SCREEN    (RADDR_SCREEN),
        .DATA_OUT_SCREEN (DATA_OUT_SCREEN),
        .WADDR_SCREEN    (WADDR_SCREEN),
        .DATA_IN_SCREEN  (DATA_IN_SCREEN),
        .MW_SCREEN_ON    (MW_SCREEN_ON)
    );

    always #5 CLK = ~CLK;

    // Screen memory: combinational read, write on the falling edge.
    logic [15:0] mem [0:2047] = '{default: 16'h0000};
    assign DATA_OUT_SCREEN = mem[RADDR_SCREEN[10:0]];
    always @(negedge CLK) begin
        if (MW_SCREEN_ON === 1'b1) mem[WADDR_SCREEN[10:0]] <= DATA_IN_SCREEN;
    end

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         wr_seen = 0;
    logic [7:0] scr [0:NROW-1][0:NCOL-1];
    int         mrow = 0;
    int         mcol = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: character grid ----------------
    function automatic logic [15:0] word_of(input int k);
        return {scr[k / WPR][(k % WPR) * 2], scr[k / WPR][(k % WPR) * 2 + 1]};
    endfunction

    task automatic set_word(input int k, input logic [15:0] v);
        scr[k / WPR][(k % WPR) * 2]     = v[15:8];
        scr[k / WPR][(k % WPR) * 2 + 1] = v[7:0];
    endtask

    task automatic push_word(input int k);
        wr_t e;
        e.addr = 16'(k);
        e.data = word_of(k);
        exp_q.push_back(e);
    endtask

    // Shift the screen up one text line, limited to the first n word writes.
    task automatic m_scroll_n(input int n);
        for (int k = 0; k < n; k++) begin
            if (k < NW - WPR) set_word(k, word_of(k + WPR));
            else              set_word(k, 16'h0000);
            push_word(k);
        end
    endtask

    task automatic m_clear();
        for (int k = 0; k < NW; k++) begin
            set_word(k, 16'h0000);
            push_word(k);
        end
        mrow = 0;
        mcol = 0;
    endtask

    task automatic m_row_adv(inout int eb);
        if (mrow < NROW - 1) mrow++;
        else begin
            m_scroll_n(NW);
            eb += 1200;
        end
    endtask

    task automatic m_char(input logic [7:0] ch, output int eb);
        eb = 0;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            scr[mrow][mcol] = ch;
            push_word(mrow * WPR + mcol / 2);
            eb = 1;
            if (mcol < NCOL - 1) mcol++;
            else begin
                mcol = 0;
                m_row_adv(eb);
            end
        end else if (ch == 8'h0A) begin
            mcol = 0;
            m_row_adv(eb);
        end else if (ch == 8'h0D) begin
            mcol = 0;
`ifdef SCREEN_CTRL_BACKSPACE_EN
        end else if (ch == 8'h08 && mcol > 0) begin
            mcol--;
            scr[mrow][mcol] = 8'h00;
            push_word(mrow * WPR + mcol / 2);
            eb = 1;
`endif
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        wr_t e;
        if (RST_N === 1'b1 && MW_SCREEN_ON === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                         WADDR_SCREEN, DATA_IN_SCREEN);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(WADDR_SCREEN), 32'(e.addr));
                chk("write_data", 32'(DATA_IN_SCREEN), 32'(e.data));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(output int n);
        n = 0;
        while (BUSY === 1'b1 && n < 5000) begin
            n++;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_cursor();
        chk("cur_row", 32'(CUR_ROW), 32'(mrow));
        chk("cur_col", 32'(CUR_COL), 32'(mcol));
    endtask

    task automatic send_char(input logic [7:0] ch);
        int eb;
        int n;
        @(negedge CLK);
        chk("ch_ready", 32'(CH_READY), 32'd1);
        m_char(ch, eb);
        CH_VALID = 1'b1;
        CH_DATA  = ch;
        @(posedge CLK);
        #1;
        CH_VALID = 1'b0;
        CH_DATA  = 8'($urandom);
        wait_idle(n);
        chk("busy_cycles", 32'(n), 32'(eb));
        check_cursor();
    endtask

    task automatic do_clear(input logic with_ch);
        int n;
        @(negedge CLK);
        CLR_REQ  = 1'b1;
        CH_VALID = with_ch;
        CH_DATA  = 8'h41;
        #1;
        chk("ch_ready_during_clr", 32'(CH_READY), 32'd0);
        m_clear();
        @(posedge CLK);
        #1;
        CLR_REQ  = 1'b0;
        CH_VALID = 1'b0;
        wait_idle(n);
        chk("clr_busy_cycles", 32'(n), 32'd1200);
        check_cursor();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int r;
        logic [7:0] ch;

        for (int i = 0; i < NROW; i++)
            for (int j = 0; j < NCOL; j++) scr[i][j] = 8'h00;

        RST_N    = 1'b0;
        CH_VALID = 1'b0;
        CLR_REQ  = 1'b0;
        CH_DATA  = 8'h00;
        #1;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_ready", 32'(CH_READY), 32'd1);
        chk("rst_mw", 32'(MW_SCREEN_ON), 32'd0);
        chk("rst_raddr", 32'(RADDR_SCREEN), 32'd0);
        chk("rst_waddr", 32'(WADDR_SCREEN), 32'd0);
        chk("rst_data_in", 32'(DATA_IN_SCREEN), 32'd0);
        check_cursor();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // Clear wins over a simultaneous character.
        do_clear(1'b1);

        // Two characters share word 0.
        send_char(8'h41);
        chk("word0_after_A", 32'(mem[0]), 32'h4100);
        send_char(8'h42);
        chk("word0_after_AB", 32'(mem[0]), 32'h4142);

        // CR / LF at (3,5), then backspace (or ignored 0x08) at (4,1).
        repeat (3) send_char(8'h0A);
        repeat (5) send_char(8'($urandom_range(32, 126)));
        send_char(8'h0D);
        send_char(8'h0A);
        send_char(8'h58);
        send_char(8'h08);
`ifdef SCREEN_CTRL_BACKSPACE_EN
        chk("word160_hi_after_bs", 32'(mem[160][15:8]), 32'h00);
`else
        chk("word160_hi_no_bs", 32'(mem[160][15:8]), 32'h58);
`endif

        // Random mix of printable, control and clear traffic.
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) do_clear(1'b0);
            else begin
                if (r < 8)       ch = 8'h0A;
                else if (r < 11) ch = 8'h0D;
                else if (r < 15) ch = 8'h08;
                else if (r < 18) ch = 8'($urandom_range(0, 31));
                else if (r < 19) ch = 8'h7F;
                else             ch = 8'($urandom_range(32, 126));
                send_char(ch);
            end
        end

        // Last cell of the screen forces a scroll.
        do_clear(1'b0);
        repeat (29) send_char(8'h0A);
        repeat (79) send_char(8'($urandom_range(32, 126)));
        send_char(8'h5A);
        chk("word1159_lo_after_scroll", 32'(mem[1159][7:0]), 32'h5A);
        chk("word1199_after_scroll", 32'(mem[1199]), 32'h0000);

        // Reset while scrolling, just before word 500 is written.
        @(negedge CLK);
        chk("ch_ready_before_lf", 32'(CH_READY), 32'd1);
        m_scroll_n(500);
        base     = wr_seen;
        CH_VALID = 1'b1;
        CH_DATA  = 8'h0A;
        @(posedge CLK);
        #1;
        CH_VALID = 1'b0;
        n = 0;
        while (wr_seen < base + 500 && n < 5000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("scroll_progress", 32'(wr_seen - base), 32'd500);
        RST_N = 1'b0;
        #1;
        mrow = 0;
        mcol = 0;
        chk("abort_mw", 32'(MW_SCREEN_ON), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_ready", 32'(CH_READY), 32'd1);
        chk("abort_waddr", 32'(WADDR_SCREEN), 32'd0);
        chk("abort_pending", 32'(exp_q.size()), 32'd0);
        check_cursor();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        repeat (6) send_char(8'($urandom_range(32, 126)));

        repeat (4) @(posedge CLK);
        chk("leftover_writes", 32'(exp_q.size()), 32'd0);
        for (int k = 0; k < NW; k++) chk($sformatf("mem_word_%0d", k), 32'(mem[k]), 32'(word_of(k)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
